// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture path.
package cam_pkg;

  localparam int unsigned AW_DEF = 21;
  localparam int unsigned PIX_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    ASRT,
    HOLD,
    DEAS
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a push on a full FIFO is taken only when a pop frees a slot.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage carries no reset; only entries below the level are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cam_capture_wbuf.sv
// Buffers a VSYNC-framed pixel stream and writes it word by word into the
// SDRAM camera port using an asrt/hold/deas handshake.
module cam_capture_wbuf
  import cam_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned AW         = AW_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic [AW-1:0]    BASE_ADDR,
  input  logic [AW-1:0]    FRAME_WORDS,
  input  logic             VSYNC,
  input  logic             PIX_VALID,
  input  logic [PIX_W-1:0] PIX_DATA,
  input  logic             CMEMRDY,
  output logic [AW-1:0]    CMEMADDR,
  output logic [PIX_W-1:0] CMEMDOUT,
  output logic             CMEMnWE_asrt,
  output logic             CMEMnWE_deas,
  input  logic             OVF_CLR,
  output logic             OVERFLOW,
  output logic             FRAME_DONE,
  output logic             BUSY
);

  localparam int unsigned LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  state_e           state_q, state_d;
  logic             vsync_q;
  logic [AW-1:0]    base_q, base_d, fw_q, fw_d;
  logic [AW-1:0]    acc_q, acc_d, wr_q, wr_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic             resync_q, resync_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [PIX_W-1:0] dout_q, dout_d;
  logic             asrt_q, asrt_d, deas_q, deas_d, done_q, done_d;
  logic             ovf_q, ovf_d, busy_q, busy_d;

  logic             rise_c, load_c, in_frame_c, accept_c, push_req_c, ovf_set_c;
  logic             f_pop, f_full, f_empty;
  logic [PIX_W-1:0] f_head;
  logic [LW-1:0]    f_level;

  sync_fifo #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push_req_c),
    .pop_i   (f_pop),
    .flush_i (load_c),
    .wdata_i (PIX_DATA),
    .rdata_o (f_head),
    .full_o  (f_full),
    .empty_o (f_empty),
    .level_o (f_level)
  );

  // Next-state, write sequencing and pixel acceptance.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    fw_d     = fw_q;
    acc_d    = acc_q;
    wr_d     = wr_q;
    hold_d   = hold_q;
    resync_d = resync_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    asrt_d   = 1'b0;
    deas_d   = 1'b0;
    done_d   = 1'b0;
    load_c   = 1'b0;
    f_pop    = 1'b0;
    rise_c   = VSYNC && !vsync_q;

    case (state_q)
      IDLE: if (ENABLE) state_d = ARM;
      ARM: begin
        if (!ENABLE) state_d = IDLE;
        else if (rise_c) begin
          load_c  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ENABLE && rise_c) load_c = 1'b1;
        else if (!f_empty && CMEMRDY) begin
          state_d = ASRT;
          asrt_d  = 1'b1;
          addr_d  = base_q + wr_q;
          dout_d  = f_head;
        end else if (!ENABLE && f_empty) state_d = IDLE;
      end
      ASRT: begin
        if (ENABLE && rise_c) resync_d = 1'b1;
        if (HOLD_CYC > 1) begin
          state_d = HOLD;
          hold_d  = HCW'(1);
        end else begin
          state_d = DEAS;
          deas_d  = 1'b1;
        end
      end
      HOLD: begin
        if (ENABLE && rise_c) resync_d = 1'b1;
        if (hold_q == HCW'(HOLD_CYC - 1)) begin
          state_d = DEAS;
          deas_d  = 1'b1;
        end else hold_d = hold_q + HCW'(1);
      end
      DEAS: begin
        f_pop    = 1'b1;
        wr_d     = wr_q + AW'(1);
        resync_d = 1'b0;
        // A frame restart requested during the write wins over completion.
        if (ENABLE && (rise_c || resync_q)) begin
          load_c  = 1'b1;
          state_d = RUN;
        end else if (wr_q + AW'(1) == fw_q) begin
          done_d  = 1'b1;
          state_d = ENABLE ? ARM : IDLE;
        end else if (!ENABLE && f_level == LW'(1)) state_d = IDLE;
        else state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      base_d   = BASE_ADDR;
      fw_d     = (FRAME_WORDS == '0) ? AW'(1) : FRAME_WORDS;
      acc_d    = '0;
      wr_d     = '0;
      resync_d = 1'b0;
    end

    in_frame_c = (state_q == RUN) || (state_q == ASRT) ||
                 (state_q == HOLD) || (state_q == DEAS);
    accept_c   = in_frame_c && ENABLE && (acc_q < fw_q) && !load_c;
    push_req_c = accept_c && PIX_VALID;
    if (push_req_c) acc_d = acc_q + AW'(1);

    // Dropped pixels still count toward the frame length.
    ovf_set_c = push_req_c && f_full && !f_pop;
    ovf_d     = ovf_set_c ? 1'b1 : (OVF_CLR ? 1'b0 : ovf_q);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      vsync_q  <= 1'b0;
      base_q   <= '0;
      fw_q     <= '0;
      acc_q    <= '0;
      wr_q     <= '0;
      hold_q   <= '0;
      resync_q <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      asrt_q   <= 1'b0;
      deas_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= VSYNC;
      base_q   <= base_d;
      fw_q     <= fw_d;
      acc_q    <= acc_d;
      wr_q     <= wr_d;
      hold_q   <= hold_d;
      resync_q <= resync_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      asrt_q   <= asrt_d;
      deas_q   <= deas_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  assign CMEMADDR     = addr_q;
  assign CMEMDOUT     = dout_q;
  assign CMEMnWE_asrt = asrt_q;
  assign CMEMnWE_deas = deas_q;
  assign OVERFLOW     = ovf_q;
  assign FRAME_DONE   = done_q;
  assign BUSY         = busy_q;

endmodule

// File: tb/tb_cam_capture_wbuf.sv
// Directed bench for cam_capture_wbuf: table of whole frames plus hand sequences.
module tb_cam_capture_wbuf;

  logic        CLK = 1'b0;
  logic        RST, ENABLE, VSYNC, PIX_VALID, CMEMRDY, OVF_CLR;
  logic [20:0] BASE_ADDR, FRAME_WORDS;
  logic [15:0] PIX_DATA;
  logic [20:0] CMEMADDR;
  logic [15:0] CMEMDOUT;
  logic        CMEMnWE_asrt, CMEMnWE_deas, OVERFLOW, FRAME_DONE, BUSY;

  cam_capture_wbuf dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .BASE_ADDR(BASE_ADDR),
    .FRAME_WORDS(FRAME_WORDS), .VSYNC(VSYNC), .PIX_VALID(PIX_VALID),
    .PIX_DATA(PIX_DATA), .CMEMRDY(CMEMRDY), .CMEMADDR(CMEMADDR),
    .CMEMDOUT(CMEMDOUT), .CMEMnWE_asrt(CMEMnWE_asrt), .CMEMnWE_deas(CMEMnWE_deas),
    .OVF_CLR(OVF_CLR), .OVERFLOW(OVERFLOW), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [20:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [20:0] base;
    logic [20:0] fw;
    int          npix;
    logic [15:0] pix0;
    int          nwr;
    logic [20:0] a0;
    logic [20:0] alast;
    int          ndone;
  } vec_t;

  wr_t         wq[$];
  int          done_cnt = 0;
  int          pair_err = 0;
  bit          in_wr = 1'b0;
  logic [20:0] cur_a;
  logic [15:0] cur_d;
  int          checks = 0;
  int          failures = 0;

  // Write monitor: every deas must close an asrt with unchanged address/data.
  always @(negedge CLK) begin
    if (RST) in_wr = 1'b0;
    else begin
      if (CMEMnWE_asrt) begin
        if (in_wr) pair_err++;
        in_wr = 1'b1;
        cur_a = CMEMADDR;
        cur_d = CMEMDOUT;
      end
      if (CMEMnWE_deas) begin
        if (!in_wr || CMEMADDR !== cur_a || CMEMDOUT !== cur_d) pair_err++;
        in_wr = 1'b0;
        wq.push_back('{CMEMADDR, CMEMDOUT});
      end
      if (FRAME_DONE) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic vsync_pulse();
    VSYNC = 1'b1;
    tick();
    VSYNC = 1'b0;
    tick();
  endtask

  task automatic push_pix(input logic [15:0] d0, input int n);
    for (int i = 0; i < n; i++) begin
      PIX_VALID = 1'b1;
      PIX_DATA  = d0 + 16'(i);
      tick();
    end
    PIX_VALID = 1'b0;
  endtask

  task automatic wait_asrt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (CMEMnWE_asrt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_writes(input string name, input int start, input int n,
                              input logic [20:0] a0, input logic [15:0] d0);
    for (int k = 0; k < n && start + k < wq.size(); k++) begin
      logic [20:0] ea;
      logic [15:0] ed;
      ea = a0 + 21'(k);
      ed = d0 + 16'(k);
      check($sformatf("%s_addr%0d", name, k), 32'(wq[start+k].addr), 32'(ea));
      check($sformatf("%s_data%0d", name, k), 32'(wq[start+k].data), 32'(ed));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   sw, sd, sp;
    bit   ok;

    vecs[0] = '{21'h000100, 21'd4, 4, 16'hA000, 4, 21'h000100, 21'h000103, 1};
    vecs[1] = '{21'h1FFFFE, 21'd4, 4, 16'hB000, 4, 21'h1FFFFE, 21'h000001, 1};
    vecs[2] = '{21'h000200, 21'd0, 3, 16'h5000, 1, 21'h000200, 21'h000200, 1};
    vecs[3] = '{21'h000300, 21'd3, 6, 16'h6000, 3, 21'h000300, 21'h000302, 1};

    RST = 1'b1; ENABLE = 1'b0; VSYNC = 1'b0; PIX_VALID = 1'b0; PIX_DATA = '0;
    CMEMRDY = 1'b0; OVF_CLR = 1'b0; BASE_ADDR = '0; FRAME_WORDS = '0;
    repeat (3) tick();
    check("rst_busy", 32'(BUSY), 0);
    check("rst_pulses", {29'd0, CMEMnWE_asrt, CMEMnWE_deas, FRAME_DONE}, 0);
    check("rst_ovf", 32'(OVERFLOW), 0);
    check("rst_addr_data", {CMEMADDR[15:0], CMEMDOUT}, 0);
    RST = 1'b0;
    tick();

    // Whole frames with memory always ready.
    ENABLE = 1'b1; CMEMRDY = 1'b1;
    for (int v = 0; v < 4; v++) begin
      sw = wq.size(); sd = done_cnt; sp = pair_err;
      BASE_ADDR = vecs[v].base; FRAME_WORDS = vecs[v].fw;
      repeat (3) tick();
      vsync_pulse();
      push_pix(vecs[v].pix0, vecs[v].npix);
      repeat (60) tick();
      check($sformatf("v%0d_nwr", v), 32'(wq.size() - sw), 32'(vecs[v].nwr));
      check_writes($sformatf("v%0d", v), sw, vecs[v].nwr, vecs[v].a0, vecs[v].pix0);
      if (wq.size() > sw)
        check($sformatf("v%0d_alast", v), 32'(wq[wq.size()-1].addr), 32'(vecs[v].alast));
      check($sformatf("v%0d_done", v), 32'(done_cnt - sd), 32'(vecs[v].ndone));
      check($sformatf("v%0d_pair", v), 32'(pair_err - sp), 0);
      check($sformatf("v%0d_ovf", v), 32'(OVERFLOW), 0);
      check($sformatf("v%0d_busy_arm", v), 32'(BUSY), 1);
    end

    // Back-pressure: 20 pixels into a 16-deep FIFO.
    sw = wq.size(); sd = done_cnt;
    CMEMRDY = 1'b0; BASE_ADDR = 21'h000400; FRAME_WORDS = 21'd20;
    tick();
    vsync_pulse();
    push_pix(16'hD000, 20);
    tick();
    check("ovf_set", 32'(OVERFLOW), 1);
    check("ovf_nowr", 32'(wq.size() - sw), 0);
    CMEMRDY = 1'b1;
    repeat (100) tick();
    check("ovf_nwr", 32'(wq.size() - sw), 16);
    check_writes("ovf", sw, 16, 21'h000400, 16'hD000);
    check("ovf_nodone", 32'(done_cnt - sd), 0);
    check("ovf_sticky", 32'(OVERFLOW), 1);
    OVF_CLR = 1'b1;
    tick();
    OVF_CLR = 1'b0;
    check("ovf_clr", 32'(OVERFLOW), 0);
    ENABLE = 1'b0;
    repeat (5) tick();
    check("ovf_idle", 32'(BUSY), 0);

    // VSYNC rise while a write is in HOLD.
    sw = wq.size(); sd = done_cnt; sp = pair_err;
    ENABLE = 1'b1; CMEMRDY = 1'b0; BASE_ADDR = 21'h000500; FRAME_WORDS = 21'd8;
    repeat (3) tick();
    vsync_pulse();
    push_pix(16'hE000, 3);
    CMEMRDY = 1'b1;
    wait_asrt(ok);
    check("mid_asrt_seen", 32'(ok), 1);
    tick();
    VSYNC = 1'b1;
    tick();
    VSYNC = 1'b0;
    tick();
    push_pix(16'hC000, 1);
    repeat (30) tick();
    check("mid_nwr", 32'(wq.size() - sw), 2);
    check_writes("mid_old", sw, 1, 21'h000500, 16'hE000);
    check_writes("mid_new", sw + 1, 1, 21'h000500, 16'hC000);
    check("mid_nodone", 32'(done_cnt - sd), 0);
    check("mid_pair", 32'(pair_err - sp), 0);
    ENABLE = 1'b0;
    repeat (5) tick();
    check("mid_idle", 32'(BUSY), 0);

    // ENABLE drop with five words buffered.
    sw = wq.size(); sd = done_cnt;
    ENABLE = 1'b1; CMEMRDY = 1'b0; BASE_ADDR = 21'h000600; FRAME_WORDS = 21'd10;
    repeat (3) tick();
    vsync_pulse();
    push_pix(16'hF000, 5);
    ENABLE = 1'b0; CMEMRDY = 1'b1;
    PIX_VALID = 1'b1; PIX_DATA = 16'h1234;
    repeat (10) tick();
    PIX_VALID = 1'b0;
    repeat (40) tick();
    check("en_nwr", 32'(wq.size() - sw), 5);
    check_writes("en", sw, 5, 21'h000600, 16'hF000);
    check("en_nodone", 32'(done_cnt - sd), 0);
    check("en_idle", 32'(BUSY), 0);

    // Asynchronous reset in the middle of a write.
    ENABLE = 1'b1; CMEMRDY = 1'b1; BASE_ADDR = 21'h000700; FRAME_WORDS = 21'd4;
    repeat (3) tick();
    vsync_pulse();
    push_pix(16'h7100, 2);
    wait_asrt(ok);
    check("rst_asrt_seen", 32'(ok), 1);
    tick();
    #1 RST = 1'b1;
    #1;
    check("arst_busy", 32'(BUSY), 0);
    check("arst_pulses", {29'd0, CMEMnWE_asrt, CMEMnWE_deas, FRAME_DONE}, 0);
    check("arst_addr", 32'(CMEMADDR), 0);
    check("arst_data", 32'(CMEMDOUT), 0);
    #4 RST = 1'b0;
    sw = wq.size(); sd = done_cnt;
    BASE_ADDR = 21'h000710; FRAME_WORDS = 21'd1;
    tick();
    push_pix(16'h9000, 20);
    repeat (10) tick();
    check("arst_nowr", 32'(wq.size() - sw), 0);
    vsync_pulse();
    push_pix(16'h7777, 1);
    repeat (30) tick();
    check("arst_nwr", 32'(wq.size() - sw), 1);
    check_writes("arst", sw, 1, 21'h000710, 16'h7777);
    check("arst_done", 32'(done_cnt - sd), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
